// File: rtl/sram_arb_ctrl_if.sv
// Requester-side bundle for the two-port SRAM arbiter: port 0 (data side) and
// port 1 (instruction side) request/response signals.
interface sram_arb_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_rdata, p0_ack, p1_rdata, p1_ack
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_rdata, p0_ack, p1_rdata, p1_ack
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-port asynchronous-SRAM controller: round-robin arbitration between the
// data and instruction requesters, one SRAM transaction at a time.
module sram_arb_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  sram_arb_ctrl_if.slave    bus,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_oe,
  output logic              sram_we
);
  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              gnt;
  logic              last;
  logic [DATA_W-1:0] wdata_q;

  logic              drv_en;
  logic              any_req;
  logic              pick;
  logic              grant_go;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The bus is only ever driven in the write states, so it can never collide with OE.
  assign drv_en    = (state == WR) || (state == WR_HOLD);
  assign sram_data = drv_en ? wdata_q : {DATA_W{1'bz}};

  // On a tie the port that was not served last wins; otherwise the lone requester.
  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
    pick    = (bus.p0_req && bus.p1_req) ? ~last : bus.p1_req;
    // A raised ack marks the dead cycle that keeps a stale request from re-granting.
    grant_go  = (state == IDLE) && any_req && !(bus.p0_ack || bus.p1_ack);
    sel_we    = pick ? bus.p1_we    : bus.p0_we;
    sel_addr  = pick ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = pick ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk_50MHz) begin
    if (grant_go) wdata_q <= sel_wdata;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= 1'b0;
      last         <= 1'b1;
      sram_addr    <= '0;
      sram_en      <= 1'b1;
      sram_oe      <= 1'b1;
      sram_we      <= 1'b1;
      bus.p0_ack   <= 1'b0;
      bus.p1_ack   <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_go) begin
            gnt       <= pick;
            last      <= pick;
            sram_addr <= sel_addr;
            cnt       <= CNT_W'(1);
            sram_en   <= 1'b0;
            if (sel_we) begin
              sram_we <= 1'b0;
              state   <= WR;
            end else begin
              sram_oe <= 1'b0;
              state   <= RD;
            end
          end
        end
        RD: begin
          if (cnt == CNT_W'(RD_CYC)) begin
            if (gnt) begin
              bus.p1_rdata <= sram_data;
              bus.p1_ack   <= 1'b1;
            end else begin
              bus.p0_rdata <= sram_data;
              bus.p0_ack   <= 1'b1;
            end
            sram_en <= 1'b1;
            sram_oe <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR: begin
          if (cnt == CNT_W'(WR_CYC)) begin
            sram_we <= 1'b1;
            state   <= WR_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_HOLD: begin
          // Data and CE were held one extra cycle past WE rising for hold time.
          sram_en <= 1'b1;
          if (gnt) bus.p1_ack <= 1'b1;
          else     bus.p0_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl: one instance at RD_CYC=WR_CYC=2 and one
// at RD_CYC=1, WR_CYC=4, each with its own asynchronous-SRAM model.
module tb_sram_arb_ctrl;
  localparam int DW = 16;
  localparam int AW = 18;

  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  sram_arb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  wire  [DW-1:0] sd_a, sd_b;
  logic [AW-1:0] sa_a, sa_b;
  logic          en_a, oe_a, we_a, en_b, oe_b, we_b;

  sram_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_CYC(2), .WR_CYC(2)) dut_a (
    .clk_50MHz(clk_50MHz), .rst(rst_a), .bus(bus_a), .sram_data(sd_a),
    .sram_addr(sa_a), .sram_en(en_a), .sram_oe(oe_a), .sram_we(we_a));

  sram_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_CYC(1), .WR_CYC(4)) dut_b (
    .clk_50MHz(clk_50MHz), .rst(rst_b), .bus(bus_b), .sram_data(sd_b),
    .sram_addr(sa_b), .sram_en(en_b), .sram_oe(oe_b), .sram_we(we_b));

  // SRAM models: unwritten locations read back their low 16 address bits.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  bit            wr_a  [0:(1<<AW)-1];
  bit            wr_b  [0:(1<<AW)-1];
  logic [DW-1:0] rdv_a, rdv_b;

  assign rdv_a = wr_a[sa_a] ? mem_a[sa_a] : sa_a[DW-1:0];
  assign rdv_b = wr_b[sa_b] ? mem_b[sa_b] : sa_b[DW-1:0];
  assign sd_a  = (!en_a && !oe_a) ? rdv_a : {DW{1'bz}};
  assign sd_b  = (!en_b && !oe_b) ? rdv_b : {DW{1'bz}};

  always @(posedge we_a) if (!en_a) begin mem_a[sa_a] <= sd_a; wr_a[sa_a] <= 1'b1; end
  always @(posedge we_b) if (!en_b) begin mem_b[sa_b] <= sd_b; wr_b[sa_b] <= 1'b1; end

  typedef struct {
    bit            port;
    bit            rd;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as required", nm);
  endtask

  task automatic wait_a(input bit port, input bit drop);
    int n = 0;
    do begin
      @(negedge clk_50MHz);
      n++;
    end while (!(port ? bus_a.p1_ack : bus_a.p0_ack) && n < 20);
    if (!(port ? bus_a.p1_ack : bus_a.p0_ack)) fail_now("a_ack_timeout");
    if (drop) begin
      if (port) bus_a.p1_req = 1'b0;
      else      bus_a.p0_req = 1'b0;
    end
  endtask

  task automatic wait_b(input bit port);
    int n = 0;
    do begin
      @(negedge clk_50MHz);
      n++;
    end while (!(port ? bus_b.p1_ack : bus_b.p0_ack) && n < 20);
    if (!(port ? bus_b.p1_ack : bus_b.p0_ack)) fail_now("b_ack_timeout");
    if (port) bus_b.p1_req = 1'b0;
    else      bus_b.p0_req = 1'b0;
  endtask

  // Monitor for instance A: pops the scoreboard on every ack.
  bit prev_ack_a = 1'b0;
  bit prev_oe_a  = 1'b1;
  bit prev_gap_a = 1'b1;
  always @(negedge clk_50MHz) begin
    if (rst_a) begin
      if (bus_a.p0_ack || bus_a.p1_ack) begin
        chk("a_ack_overlap", 32'(bus_a.p0_ack & bus_a.p1_ack), 32'd0);
        if (q_a.size() == 0) fail_now("a_unexpected_ack");
        else begin
          ea = q_a.pop_front();
          chk("a_ack_port", 32'(bus_a.p1_ack), 32'(ea.port));
          chk("a_ack_cycle", cyc, ea.cyc);
          if (ea.rd) chk("a_rdata", 32'(ea.port ? bus_a.p1_rdata : bus_a.p0_rdata), 32'(ea.data));
        end
      end
      if (prev_ack_a) chk("a_dead_cycle", {30'd0, bus_a.p0_ack | bus_a.p1_ack, en_a}, 32'd1);
      if (!oe_a || dut_a.drv_en) chk("a_oe_and_drive", 32'(!oe_a && dut_a.drv_en), 32'd0);
      if (!oe_a && prev_oe_a) chk("a_idle_before_oe", 32'(prev_gap_a), 32'd1);
    end
    prev_ack_a = bus_a.p0_ack | bus_a.p1_ack;
    prev_oe_a  = oe_a;
    prev_gap_a = en_a && !dut_a.drv_en;
  end

  // Monitor for instance B.
  always @(negedge clk_50MHz) begin
    if (rst_b) begin
      if (bus_b.p0_ack || bus_b.p1_ack) begin
        if (q_b.size() == 0) fail_now("b_unexpected_ack");
        else begin
          eb = q_b.pop_front();
          chk("b_ack_port", 32'(bus_b.p1_ack), 32'(eb.port));
          chk("b_ack_cycle", cyc, eb.cyc);
          if (eb.rd) chk("b_rdata", 32'(eb.port ? bus_b.p1_rdata : bus_b.p0_rdata), 32'(eb.data));
        end
      end
      if (!oe_b || dut_b.drv_en) chk("b_oe_and_drive", 32'(!oe_b && dut_b.drv_en), 32'd0);
    end
  end

  logic [AW-1:0] pa0 [3];
  logic [AW-1:0] pa1 [3];
  int c;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.p0_req = 1'b0; bus_a.p0_we = 1'b0; bus_a.p0_addr = '0; bus_a.p0_wdata = '0;
    bus_a.p1_req = 1'b0; bus_a.p1_we = 1'b0; bus_a.p1_addr = '0; bus_a.p1_wdata = '0;
    bus_b.p0_req = 1'b0; bus_b.p0_we = 1'b0; bus_b.p0_addr = '0; bus_b.p0_wdata = '0;
    bus_b.p1_req = 1'b0; bus_b.p1_we = 1'b0; bus_b.p1_addr = '0; bus_b.p1_wdata = '0;
    pa0[0] = 18'h00010; pa0[1] = 18'h00020; pa0[2] = 18'h00123;
    pa1[0] = 18'h00011; pa1[1] = 18'h00021; pa1[2] = 18'h3FFFF;
    repeat (3) @(negedge clk_50MHz);

    chk("a_rst_en", 32'(en_a), 32'd1);
    chk("a_rst_oe", 32'(oe_a), 32'd1);
    chk("a_rst_we", 32'(we_a), 32'd1);
    chk("a_rst_addr", 32'(sa_a), 32'd0);
    chk("a_rst_drive", 32'(dut_a.drv_en), 32'd0);
    chk("a_rst_ack", {30'd0, bus_a.p0_ack, bus_a.p1_ack}, 32'd0);
    chk("a_rst_rdata", {bus_a.p0_rdata, bus_a.p1_rdata}, 32'd0);
    chk("b_rst_en", 32'(en_b), 32'd1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk_50MHz);

    // Port-0 write 0x3A5C to 0x00123: WE low two cycles, then one hold cycle.
    c = cyc;
    bus_a.p0_req = 1'b1; bus_a.p0_we = 1'b1; bus_a.p0_addr = 18'h00123; bus_a.p0_wdata = 16'h3A5C;
    q_a.push_back('{port: 1'b0, rd: 1'b0, data: 16'h0, cyc: c + 4});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_50MHz);
      chk("a_wr_we", 32'(we_a), (i <= 2) ? 32'd0 : 32'd1);
      chk("a_wr_en", 32'(en_a), 32'd0);
      chk("a_wr_drive", 32'(dut_a.drv_en), 32'd1);
      chk("a_wr_addr", 32'(sa_a), 32'h00123);
    end
    wait_a(1'b0, 1'b1);
    @(negedge clk_50MHz);

    // Port-0 read back, ack three edges after the grant.
    c = cyc;
    bus_a.p0_req = 1'b1; bus_a.p0_we = 1'b0; bus_a.p0_addr = 18'h00123;
    q_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'h3A5C, cyc: c + 3});
    wait_a(1'b0, 1'b1);
    @(negedge clk_50MHz);

    // Port-1 read of the top address; port-0 read data must stay put.
    c = cyc;
    bus_a.p1_req = 1'b1; bus_a.p1_we = 1'b0; bus_a.p1_addr = 18'h3FFFF;
    q_a.push_back('{port: 1'b1, rd: 1'b1, data: 16'hFFFF, cyc: c + 3});
    wait_a(1'b1, 1'b1);
    chk("a_p1_rdata_max", 32'(bus_a.p1_rdata), 32'h0000FFFF);
    chk("a_p0_rdata_kept", 32'(bus_a.p0_rdata), 32'h00003A5C);
    @(negedge clk_50MHz);

    // Both ports reading continuously: grants 0,1,0,1,0,1 four cycles apart.
    c = cyc;
    q_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'h0010, cyc: c + 3});
    q_a.push_back('{port: 1'b1, rd: 1'b1, data: 16'h0011, cyc: c + 7});
    q_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'h0020, cyc: c + 11});
    q_a.push_back('{port: 1'b1, rd: 1'b1, data: 16'h0021, cyc: c + 15});
    q_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'h3A5C, cyc: c + 19});
    q_a.push_back('{port: 1'b1, rd: 1'b1, data: 16'hFFFF, cyc: c + 23});
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          bus_a.p0_req = 1'b1; bus_a.p0_we = 1'b0; bus_a.p0_addr = pa0[j];
          wait_a(1'b0, j == 2);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          bus_a.p1_req = 1'b1; bus_a.p1_we = 1'b0; bus_a.p1_addr = pa1[k];
          wait_a(1'b1, k == 2);
        end
      end
    join
    @(negedge clk_50MHz);

    // Write immediately followed by a read of the same word.
    c = cyc;
    bus_a.p0_req = 1'b1; bus_a.p0_we = 1'b1; bus_a.p0_addr = 18'h00030; bus_a.p0_wdata = 16'h5A5A;
    q_a.push_back('{port: 1'b0, rd: 1'b0, data: 16'h0, cyc: c + 4});
    q_a.push_back('{port: 1'b0, rd: 1'b1, data: 16'h5A5A, cyc: c + 8});
    wait_a(1'b0, 1'b0);
    bus_a.p0_we = 1'b0;
    wait_a(1'b0, 1'b1);
    @(negedge clk_50MHz);

    // Reset asserted in the middle of a port-1 write.
    bus_a.p1_req = 1'b1; bus_a.p1_we = 1'b1; bus_a.p1_addr = 18'h00200; bus_a.p1_wdata = 16'hBEEF;
    @(negedge clk_50MHz);
    chk("a_pre_rst_we", 32'(we_a), 32'd0);
    #5 rst_a = 1'b0;
    #1;
    chk("a_mid_rst_en", 32'(en_a), 32'd1);
    chk("a_mid_rst_oe", 32'(oe_a), 32'd1);
    chk("a_mid_rst_we", 32'(we_a), 32'd1);
    chk("a_mid_rst_drive", 32'(dut_a.drv_en), 32'd0);
    chk("a_mid_rst_addr", 32'(sa_a), 32'd0);
    chk("a_mid_rst_ack", {30'd0, bus_a.p0_ack, bus_a.p1_ack}, 32'd0);
    chk("a_mid_rst_rdata", {bus_a.p0_rdata, bus_a.p1_rdata}, 32'd0);
    bus_a.p1_req = 1'b0;
    @(negedge clk_50MHz);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50MHz);
      chk("a_post_rst_idle", {30'd0, en_a, dut_a.drv_en}, 32'd2);
    end

    // Instance B: WE low four cycles, write ack six edges after grant.
    c = cyc;
    bus_b.p0_req = 1'b1; bus_b.p0_we = 1'b1; bus_b.p0_addr = 18'h00040; bus_b.p0_wdata = 16'h1234;
    q_b.push_back('{port: 1'b0, rd: 1'b0, data: 16'h0, cyc: c + 6});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_50MHz);
      chk("b_wr_we", 32'(we_b), (i <= 4) ? 32'd0 : 32'd1);
      chk("b_wr_en", 32'(en_b), 32'd0);
    end
    wait_b(1'b0);
    @(negedge clk_50MHz);

    // Instance B: one-cycle OE, read ack two edges after grant.
    c = cyc;
    bus_b.p1_req = 1'b1; bus_b.p1_we = 1'b0; bus_b.p1_addr = 18'h00040;
    q_b.push_back('{port: 1'b1, rd: 1'b1, data: 16'h1234, cyc: c + 2});
    @(negedge clk_50MHz);
    chk("b_rd_oe", 32'(oe_b), 32'd0);
    wait_b(1'b1);
    chk("b_rd_oe_released", 32'(oe_b), 32'd1);
    chk("b_p0_rdata_kept", 32'(bus_b.p0_rdata), 32'd0);

    repeat (3) @(negedge clk_50MHz);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Parametrised two-port asynchronous-SRAM controller: a successor to the single-port SRAM driver. It arbitrates round-robin between two requesters, port 0 (data side) and port 1 (instruction side), and runs one SRAM transaction at a time with programmable read and write pulse lengths. Each completed transaction returns a one-cycle ack. It sits between the CPU memory stages and the board's external SRAM pins.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 18, address width
- RD_CYC, 2, cycles CE/OE held low before read data is captured (≥1)
- WR_CYC, 2, cycles WE held low per write (≥1)

- clk_50MHz  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- p0_req / p1_req  in  1  request; held high until ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high
- p0_addr / p1_addr  in  ADDR_W  address; stable while req is high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req is high
- p0_rdata / p1_rdata  out  DATA_W  registered read data for that port
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- sram_data  inout  DATA_W  SRAM data bus
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_en / sram_oe / sram_we  out  1  active-low CE/OE/WE, registered

## Operation
- States: IDLE, RD, WR, WR_HOLD. Internal registers:
  - cnt: width clog2(max(RD_CYC,WR_CYC)+1).
  - gnt: granted port.
  - last: port granted most recently.
- IDLE:
  - sram_en, sram_oe and sram_we are 1; sram_data is Z.
  - No grant is made in a cycle where either ack is high; this is the ack dead cycle.
  - Otherwise:
    - If only one req is high, that port is granted.
    - If both are high, the port ≠ last is granted.
  - On grant, latch addr, we and wdata into sram_addr and the internal regs, and set gnt and last. Set cnt=1.
  - For a read, go to RD with sram_en=0 and sram_oe=0.
  - For a write, go to WR with sram_en=0 and sram_we=0.
- RD:
  - If cnt<RD_CYC, increment cnt.
  - At cnt==RD_CYC:
    - Capture sram_data into p{gnt}_rdata and pulse p{gnt}_ack.
    - Raise sram_en and sram_oe, and go to IDLE.
- WR:
  - sram_data is driven with the latched wdata.
  - If cnt<WR_CYC, increment cnt.
  - At cnt==WR_CYC, raise sram_we (sram_en stays 0) and go to WR_HOLD.
- WR_HOLD:
  - Data is still driven and sram_en=0 (hold time).
  - Next edge: raise sram_en, release the bus, pulse p{gnt}_ack, go to IDLE.
- sram_data is driven only in WR and WR_HOLD. It is never driven while sram_oe=0.
- Read data registers change only on a read completion for their own port. Writes and other-port reads leave them unchanged.
- Reset (asynchronous, at any time, including mid-transaction):
  - State goes to IDLE; sram_en, sram_oe and sram_we go to 1; sram_addr goes to 0.
  - sram_data goes to Z; acks and rdata go to 0; cnt goes to 0; last goes to 1 (port 0 wins the first tie).
  - An in-flight transaction is dropped with no ack.

## Timing
- Edge E0 is the edge at which IDLE grants.
- Read:
  - sram_oe is low for RD_CYC cycles.
  - Data is sampled at edge E0+RD_CYC.
  - ack and rdata are valid in the cycle after that edge.
  - Latency from the grant edge to ack is RD_CYC+1 edges.
- Write:
  - sram_we is low for WR_CYC cycles, followed by 1 hold cycle.
  - ack is high in the cycle after edge E0+WR_CYC+1.
- Requester rule: drop req, or present a new transaction, before the edge ending its ack cycle. The ack dead cycle prevents a re-grant of a stale request.
- Minimum spacing between grants:
  - RD_CYC+2 cycles for reads.
  - WR_CYC+3 cycles for writes.
- Both reqs held continuously: grants alternate 0,1,0,1; neither port waits more than one transaction.
- A req that rises during a busy transaction waits; it is evaluated in the first non-ack IDLE cycle.

## Test plan
- Reset mid-write: assert rst low at RD_CYC=WR_CYC=2, state WR → same cycle sram_en/oe/we=1, bus Z, no ack; after release, IDLE.
- Port-0 write 0x3A5C to address 0x00123, then port-0 read of 0x00123 against an SRAM model:
  - Write: sram_we low 2 cycles, then 1 hold cycle.
  - Read: p0_ack with p0_rdata=0x3A5C, exactly 3 edges after the read grant.
- p1-only read of 0x3FFFF (max address) returning 0xFFFF → p1_rdata=0xFFFF; p0_rdata unchanged.
- Both ports requesting reads continuously for 6 transactions → grants 0,1,0,1,0,1; each ack followed by one dead cycle; no ack overlap.
- Write followed immediately by a read: bus is Z and sram_en=1 for ≥1 cycle before sram_oe falls; sram_oe and the data driver are never active together (assertion).
- Rebuild with RD_CYC=1, WR_CYC=4:
  - Read ack 2 edges after grant.
  - Write shows sram_we low 4 cycles and ack 6 edges after grant.
